// File: rtl/uart_pkg.sv
// uart_pkg: shared types and constants for the UART transmit path
package uart_pkg;

    typedef enum logic [1:0] {IDLE, LAUNCH, HOLD, GAP} feeder_state_t;

    localparam int UART_DATA_W     = 7;
    localparam int UART_BAUD_TICKS = 521;
    // half-bit start + 9 bit periods + stop, rounded up to the next thousand cycles
    localparam int UART_FRAME_CYCLES = ((UART_BAUD_TICKS * 21 / 2 + 999) / 1000) * 1000;

endpackage

// File: rtl/uart_sync_fifo.sv
// uart_sync_fifo: single-clock FIFO with registered full/empty/count; writes while full are dropped
module uart_sync_fifo #(
    parameter int DEPTH  = 8,
    parameter int DATA_W = 7
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   wr,
    input  logic [DATA_W-1:0]      wr_data,
    input  logic                   rd,
    output logic [DATA_W-1:0]      rd_data,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wp, rp;
    logic [AW:0]       cnt_nxt;
    logic              do_wr, do_rd;

    assign do_wr   = wr && !full;
    assign do_rd   = rd && !empty;
    assign rd_data = mem[rp];
    assign cnt_nxt = count + (AW+1)'(do_wr) - (AW+1)'(do_rd);

    // storage array; contents are don't-care until written so it carries no reset
    always_ff @(posedge clk) begin
        if (do_wr) mem[wp] <= wr_data;
    end

    // pointers wrap naturally at the power-of-two depth; flags are registered from the next count
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wp    <= '0;
            rp    <= '0;
            count <= '0;
            full  <= 1'b0;
            empty <= 1'b1;
        end else begin
            if (do_wr) wp <= wp + 1'b1;
            if (do_rd) rp <= rp + 1'b1;
            count <= cnt_nxt;
            full  <= cnt_nxt == (AW+1)'(DEPTH);
            empty <= cnt_nxt == '0;
        end
    end

endmodule

// File: rtl/uart_tx_feeder.sv
// uart_tx_feeder: queues host characters and launches paced frames into a busy-less UART transmitter
// Optional overflow flag (ovf/ovf_clr) enabled by defining UART_TX_FEEDER_OVF_EN.
module uart_tx_feeder
    import uart_pkg::*;
#(
    parameter int DEPTH        = 8,
    parameter int DATA_W       = UART_DATA_W,
    parameter int FRAME_CYCLES = UART_FRAME_CYCLES,
    parameter int GAP_CYCLES   = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   wr_en,
    input  logic [DATA_W-1:0]      wr_data,
`ifdef UART_TX_FEEDER_OVF_EN
    input  logic                   ovf_clr,
    output logic                   ovf,
`endif
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count,
    output logic                   busy,
    output logic                   tx_start,
    output logic [DATA_W-1:0]      datain_tx
);

    localparam int FW = $clog2(FRAME_CYCLES);
    localparam int GW = GAP_CYCLES > 1 ? $clog2(GAP_CYCLES) : 1;
    localparam logic [FW-1:0] FRAME_LAST = FW'(FRAME_CYCLES - 1);
    localparam logic [GW-1:0] GAP_LAST   = GW'(GAP_CYCLES - 1);

    feeder_state_t     state, state_nxt;
    logic [FW-1:0]     frame_cnt;
    logic [GW-1:0]     gap_cnt;
    logic [DATA_W-1:0] fifo_head;
    logic              pop;

    uart_sync_fifo #(.DEPTH(DEPTH), .DATA_W(DATA_W)) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr      (wr_en),
        .wr_data (wr_data),
        .rd      (pop),
        .rd_data (fifo_head),
        .full    (full),
        .empty   (empty),
        .count   (count)
    );

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // next-state: one launch cycle, a timed hold, then an optional idle gap
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (!empty) state_nxt = LAUNCH;
            LAUNCH:  state_nxt = HOLD;
            HOLD:    if (frame_cnt == FRAME_LAST) state_nxt = (GAP_CYCLES == 0) ? IDLE : GAP;
            GAP:     if (gap_cnt == GAP_LAST) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // output decode: the head is popped on the edge that leaves IDLE
    always_comb begin
        pop = (state == IDLE) && !empty;
    end

    // registered outputs and frame/gap timers; timers sit at zero outside their own state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_start  <= 1'b0;
            busy      <= 1'b0;
            datain_tx <= '0;
            frame_cnt <= '0;
            gap_cnt   <= '0;
        end else begin
            tx_start  <= pop;
            busy      <= state_nxt != IDLE;
            if (pop) datain_tx <= fifo_head;
            frame_cnt <= (state == HOLD && state_nxt == HOLD) ? frame_cnt + 1'b1 : '0;
            gap_cnt   <= (state == GAP && state_nxt == GAP) ? gap_cnt + 1'b1 : '0;
        end
    end

`ifdef UART_TX_FEEDER_OVF_EN
    // sticky overflow flag; a dropped write outranks a clear on the same edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)              ovf <= 1'b0;
        else if (wr_en && full)  ovf <= 1'b1;
        else if (ovf_clr)        ovf <= 1'b0;
    end
`endif

endmodule

// File: doc/uart_tx_feeder.md
Name: uart_tx_feeder

Overview:
- Buffers 7-bit characters written by the host and feeds them one at a time to the UART transmitter.
- Drives the transmitter's tx_start and datain_tx inputs.
- The transmitter has no busy/done output, so this block paces frames with an internal frame timer.
- Holds datain_tx stable for the whole frame and inserts a configurable idle gap between frames.

Parameters:
- DEPTH, 8: FIFO entries; power of two, >= 2.
- DATA_W, 7: character width; matches the transmitter's 7 data bits.
- FRAME_CYCLES, 6000: clk cycles one transmitter frame occupies (half-bit start + 9 bit periods + stop at 521 clk/bit, rounded up); must be >= 2.
- GAP_CYCLES, 16: idle clk cycles between the end of one frame and the next launch; 0 means no gap.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- wr_en  in  1  host write strobe
- wr_data  in  DATA_W  character to queue
- full  out  1  FIFO holds DEPTH entries
- empty  out  1  FIFO holds 0 entries
- count  out  $clog2(DEPTH)+1  current occupancy
- busy  out  1  frame in progress (LAUNCH/HOLD/GAP)
- tx_start  out  1  one-cycle launch pulse to the transmitter
- datain_tx  out  DATA_W  character to the transmitter; stable from launch to end of HOLD

Behaviour:
- Interface (already decided): one clock, clk; reset is asynchronous and active-low, rst_n.
- Reset values:
  - empty=1, full=0, count=0, busy=0, tx_start=0, datain_tx=0.
  - FIFO pointers are 0, the FSM is in IDLE, and the frame/gap counters are 0.
- All outputs are registered.
- Write: accepted on a clk edge when wr_en=1 and full=0; count increments on that edge.
  - A write while full is dropped; FIFO contents and count are unchanged, even if a pop occurs on the same edge.
- FSM states: IDLE, LAUNCH, HOLD, GAP.
  - IDLE: if empty=0 on an edge, pop the head into datain_tx, set tx_start<=1, and go to LAUNCH; count decrements.
  - LAUNCH: lasts exactly 1 cycle. tx_start<=0, clear the frame counter, go to HOLD.
  - HOLD: the frame counter increments each cycle. When it reaches FRAME_CYCLES-1, go to GAP, or to IDLE if GAP_CYCLES=0.
  - GAP: the gap counter runs 0..GAP_CYCLES-1, then the FSM goes to IDLE.
  - busy=1 in LAUNCH, HOLD and GAP.
- Latency:
  - Write accepted at edge E0 into an empty FIFO.
  - Pop at E1; tx_start is high between E1 and E2.
  - The next launch happens no earlier than 1+FRAME_CYCLES+GAP_CYCLES+1 cycles after the previous one.
- Simultaneous write and pop (not full, not empty): both take effect and count is unchanged.
  - A write into an empty FIFO is not poppable on the same edge.
- Pointers wrap modulo DEPTH; full=(count==DEPTH), empty=(count==0).
- datain_tx changes only on a pop edge; it holds its last value while idle.
- Reset mid-frame: everything returns to reset values immediately and queued data is discarded.
  - The downstream transmitter is not reset by this block; a frame already in flight finishes with datain_tx=0.

Optional Feature:
- Macro: UART_TX_FEEDER_OVF_EN.
- When defined:
  - Adds output ovf (1 bit, reset 0). It is set on any edge where wr_en=1 and full=1, and is sticky.
  - Adds input ovf_clr (1 bit). It clears ovf on the next edge; if a set and a clear occur on the same edge, set wins.
- When undefined: neither port exists, and dropped writes are silent.

Decomposition:
- Package uart_pkg holds:
  - the feeder state enum (IDLE, LAUNCH, HOLD, GAP);
  - the UART_DATA_W=7 constant;
  - the UART_BAUD_TICKS=521 constant;
  - a UART_FRAME_CYCLES constant derived from the baud ticks.
- Sub-module uart_sync_fifo (DEPTH, DATA_W; wr/rd strobes, full/empty/count) is natural.
  - The FSM and timers stay in the top-level block.

Test Plan (bench uses DEPTH=4, FRAME_CYCLES=20, GAP_CYCLES=4):
- Single write 7'h55 at E0 -> tx_start high exactly in cycle E1..E2, datain_tx=7'h55 held for 21 cycles, busy high 25 cycles, then empty=1, busy=0.
- Burst-write 7'h01,7'h02,7'h03 back-to-back -> three tx_start pulses 26 cycles apart, datain_tx sequence 01,02,03, count returns to 0.
- 6 writes with no pop possible (all while busy) -> count saturates at 4, full=1, 5th/6th dropped; transmitted order is the first 4 values; with UART_TX_FEEDER_OVF_EN, ovf=1 until ovf_clr pulse.
- Write on the same edge as a pop with count=2 -> count stays 2, no data lost or duplicated.
- Assert rst_n=0 mid-HOLD with 2 queued -> outputs return to reset values asynchronously; after release no tx_start occurs until a new write.
- GAP_CYCLES=0 rebuild, two queued writes -> launches exactly 22 cycles apart.
